player_missile: RTL and testbench

- Upstream of the colour mapper: owns the player's single missile and produces its on-screen position and visibility for pixel drawing.
- Launches from the ship on a fire keycode and climbs a fixed step per frame.
- Retires the missile on a collision hit or when it reaches the top of the screen, then enforces a cooldown before the next shot.
- Shares the Clk / Reset / frame_clk interface used by the ship motion block.

---
 rtl/player_missile.sv | 124 ++++++++++++
 tb/tb_player_missile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_missile.sv
// Player missile: launches from the ship on the fire key, climbs STEP pixels per frame,
// retires on a hit or at the top of the screen, then waits out a cooldown.
module player_missile #(
    parameter logic [7:0]  FIRE_KEY        = 8'h2C,
    parameter int unsigned STEP            = 6,
    parameter int unsigned LAUNCH_OFS      = 16,
    parameter int unsigned Y_MIN           = 0,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned MISSILE_SIZE    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] ShipX,
    input  logic [9:0] ShipY,
    input  logic       hit,
    output logic [9:0] MissileX,
    output logic [9:0] MissileY,
    output logic [9:0] Missile_size,
    output logic       Missile_on,
    output logic       kill
);

    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

    localparam int unsigned CDW        = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [10:0] LAUNCH_MIN = 11'(LAUNCH_OFS + Y_MIN);
    localparam logic [10:0] TOP_LIMIT  = 11'(Y_MIN + STEP);

    state_t         r_state, w_state_n;
    logic           r_frame_d, r_fc_low, w_tick;
    logic           r_armed, r_hit_pend, w_armed_n, w_hit_pend_n;
    logic [CDW-1:0] r_cd, w_cd_n;
    logic [9:0]     r_mx, r_my, w_mx_n, w_my_n;
    logic           r_on, r_kill, w_on_n, w_kill_n;
    logic           w_fire, w_can_launch, w_hit_now, w_at_top;

    // r_fc_low gates the edge detector so a frame_clk already high at reset release
    // must drop before it can produce a tick; it samples the level during reset.
    assign w_tick       = frame_clk & ~r_frame_d & r_fc_low;
    assign w_fire       = (keycode == FIRE_KEY);
    assign w_can_launch = w_fire && r_armed && ({1'b0, ShipY} >= LAUNCH_MIN);
    assign w_hit_now    = r_hit_pend | hit;
    assign w_at_top     = ({1'b0, r_my} < TOP_LIMIT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_frame_d  <= 1'b0;
            r_fc_low   <= ~frame_clk;
            r_armed    <= 1'b1;
            r_hit_pend <= 1'b0;
            r_cd       <= '0;
            r_mx       <= '0;
            r_my       <= '0;
            r_on       <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_frame_d  <= frame_clk;
            r_fc_low   <= r_fc_low | ~frame_clk;
            r_armed    <= w_armed_n;
            r_hit_pend <= w_hit_pend_n;
            r_cd       <= w_cd_n;
            r_mx       <= w_mx_n;
            r_my       <= w_my_n;
            r_on       <= w_on_n;
            r_kill     <= w_kill_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (w_tick) begin
            unique case (r_state)
                IDLE:     if (w_can_launch) w_state_n = FLYING;
                FLYING:   if (w_hit_now || w_at_top) w_state_n = COOLDOWN;
                COOLDOWN: if (r_cd == '0) w_state_n = IDLE;
                default:  w_state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        w_mx_n       = r_mx;
        w_my_n       = r_my;
        w_cd_n       = r_cd;
        w_kill_n     = 1'b0;
        w_on_n       = (w_state_n == FLYING);
        w_armed_n    = r_armed | ~w_fire;
        w_hit_pend_n = (w_state_n == FLYING) && (r_hit_pend || (r_state == FLYING && hit));
        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (w_can_launch) begin
                        w_mx_n    = ShipX;
                        w_my_n    = ShipY - 10'(LAUNCH_OFS);
                        w_armed_n = 1'b0;
                    end
                end
                FLYING: begin
                    if (w_hit_now) begin
                        w_kill_n = 1'b1;
                        w_cd_n   = CDW'(COOLDOWN_FRAMES - 1);
                    end else if (w_at_top) begin
                        w_cd_n = CDW'(COOLDOWN_FRAMES - 1);
                    end else begin
                        w_my_n = r_my - 10'(STEP);
                    end
                end
                COOLDOWN: if (r_cd != '0) w_cd_n = r_cd - CDW'(1);
                default: ;
            endcase
        end
    end

    assign MissileX     = r_mx;
    assign MissileY     = r_my;
    assign Missile_size = 10'(MISSILE_SIZE);
    assign Missile_on   = r_on;
    assign kill         = r_kill;

endmodule

// File: tb/tb_player_missile.sv
// Self-checking bench for player_missile: directed scenarios plus randomized
// stimulus compared against a frame-level behavioural model.
module tb_player_missile;

    localparam int FIRE   = 8'h2C;
    localparam int STEP   = 6;
    localparam int OFS    = 16;
    localparam int CDFRM  = 8;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, hit;
    logic [7:0] keycode;
    logic [9:0] ShipX, ShipY;
    logic [9:0] MissileX, MissileY, Missile_size;
    logic       Missile_on, kill;

    int n_cmp = 0;
    int n_bad = 0;
    int kills_seen = 0;

    // Reference model state, advanced once per Clk edge
    bit m_fly = 0, m_kill = 0, m_armed = 1, m_pend = 0, m_prev = 0;
    int m_x = 0, m_y = 0, m_cd = 0;

    player_missile #(
        .FIRE_KEY(8'h2C), .STEP(6), .LAUNCH_OFS(16), .Y_MIN(0),
        .COOLDOWN_FRAMES(8), .MISSILE_SIZE(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .ShipX(ShipX), .ShipY(ShipY), .hit(hit),
        .MissileX(MissileX), .MissileY(MissileY), .Missile_size(Missile_size),
        .Missile_on(Missile_on), .kill(kill)
    );

    always #5 Clk = ~Clk;

    // m_cd counts cooldown ticks still to be spent; the missile is idle once it is zero
    function automatic void model_step();
        bit tk, was_fly;
        if (Reset) begin
            m_fly = 0; m_kill = 0; m_armed = 1; m_pend = 0; m_cd = 0;
            m_x = 0; m_y = 0; m_prev = frame_clk;
            return;
        end
        tk = frame_clk && !m_prev;
        m_prev = frame_clk;
        m_kill = 0;
        was_fly = m_fly;
        if (tk) begin
            if (m_fly) begin
                if (m_pend || hit) begin m_fly = 0; m_kill = 1; m_cd = CDFRM; end
                else if (m_y < STEP) begin m_fly = 0; m_cd = CDFRM; end
                else m_y = m_y - STEP;
            end else if (m_cd > 0) begin
                m_cd = m_cd - 1;
            end else if (keycode == FIRE && m_armed && ShipY >= OFS) begin
                m_fly = 1; m_x = ShipX; m_y = ShipY - OFS; m_armed = 0;
            end
        end
        if (!m_fly) m_pend = 0;
        else if (was_fly) m_pend = m_pend | hit;
        if (keycode != FIRE) m_armed = 1;
    endfunction

    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        if (kill === 1'b1) kills_seen++;
    endtask

    task automatic tick();
        frame_clk = 1'b1; step();
        frame_clk = 1'b0; step();
    endtask

    task automatic test_reset();
        Reset = 1'b1; step(); step();
        n_cmp++; if (Missile_on !== 1'b0) begin n_bad++; $display("FAIL reset_on: got %b want 0", Missile_on); end
        n_cmp++; if (kill !== 1'b0) begin n_bad++; $display("FAIL reset_kill: got %b want 0", kill); end
        n_cmp++; if (MissileX !== 10'd0 || MissileY !== 10'd0) begin n_bad++; $display("FAIL reset_pos: got %0d,%0d want 0,0", MissileX, MissileY); end
        n_cmp++; if (Missile_size !== 10'd2) begin n_bad++; $display("FAIL size: got %0d want 2", Missile_size); end
        Reset = 1'b0; step();
    endtask

    task automatic test_launch_climb();
        int k0;
        ShipX = 10'd320; ShipY = 10'd440; keycode = 8'h2C;
        tick();
        n_cmp++; if ({Missile_on, MissileX, MissileY} !== {1'b1, 10'd320, 10'd424}) begin
            n_bad++; $display("FAIL launch: got on=%b x=%0d y=%0d want on=1 x=320 y=424", Missile_on, MissileX, MissileY); end
        k0 = kills_seen;
        for (int k = 1; k <= 70; k++) begin
            tick();
            n_cmp++; if (Missile_on !== 1'b1 || MissileY !== 10'(424 - STEP * k)) begin
                n_bad++; $display("FAIL climb_%0d: got on=%b y=%0d want on=1 y=%0d", k, Missile_on, MissileY, 424 - STEP * k); end
        end
        tick();
        n_cmp++; if (Missile_on !== 1'b0 || MissileY !== 10'd4) begin
            n_bad++; $display("FAIL top_retire: got on=%b y=%0d want on=0 y=4", Missile_on, MissileY); end
        n_cmp++; if (kills_seen != k0) begin n_bad++; $display("FAIL top_kill: got %0d pulses want 0", kills_seen - k0); end
    endtask

    task automatic test_key_hold();
        for (int k = 0; k < CDFRM + 4; k++) begin
            tick();
            n_cmp++; if (Missile_on !== 1'b0) begin n_bad++; $display("FAIL hold_norepeat_%0d: got on=%b want 0", k, Missile_on); end
        end
        keycode = 8'h00; step();
        keycode = 8'h2C; tick();
        n_cmp++; if (Missile_on !== 1'b1 || MissileY !== 10'd424) begin
            n_bad++; $display("FAIL rearm_launch: got on=%b y=%0d want on=1 y=424", Missile_on, MissileY); end
    endtask

    task automatic test_hit();
        int k0;
        Reset = 1'b1; step(); Reset = 1'b0; step();
        ShipX = 10'd77; ShipY = 10'd440; keycode = 8'h2C;
        tick();
        for (int k = 0; k < 10; k++) tick();
        n_cmp++; if (MissileY !== 10'd364) begin n_bad++; $display("FAIL hit_pre_y: got %0d want 364", MissileY); end
        k0 = kills_seen;
        hit = 1'b1; step(); hit = 1'b0; step();
        n_cmp++; if (Missile_on !== 1'b1 || kills_seen != k0) begin
            n_bad++; $display("FAIL hit_latched_early: got on=%b kills=%0d want on=1 kills=0", Missile_on, kills_seen - k0); end
        tick();
        n_cmp++; if ({Missile_on, MissileX, MissileY} !== {1'b0, 10'd77, 10'd364}) begin
            n_bad++; $display("FAIL hit_retire: got on=%b x=%0d y=%0d want on=0 x=77 y=364", Missile_on, MissileX, MissileY); end
        n_cmp++; if (kills_seen != k0 + 1) begin n_bad++; $display("FAIL hit_kill: got %0d pulses want 1", kills_seen - k0); end
    endtask

    task automatic test_back_to_back();
        keycode = 8'h00; step(); keycode = 8'h2C;
        for (int k = 1; k <= CDFRM; k++) begin
            tick();
            n_cmp++; if (Missile_on !== 1'b0) begin n_bad++; $display("FAIL cooldown_%0d: got on=%b want 0", k, Missile_on); end
        end
        tick();
        n_cmp++; if (Missile_on !== 1'b1 || MissileY !== 10'd424) begin
            n_bad++; $display("FAIL relaunch_9th: got on=%b y=%0d want on=1 y=424", Missile_on, MissileY); end
        ShipX = 10'd500; ShipY = 10'd300;
        tick();
        n_cmp++; if (MissileX !== 10'd77 || MissileY !== 10'd418) begin
            n_bad++; $display("FAIL latch_x: got x=%0d y=%0d want x=77 y=418", MissileX, MissileY); end
    endtask

    task automatic test_reset_midflight();
        int k0 = kills_seen;
        Reset = 1'b1; step();
        n_cmp++; if ({Missile_on, kill, MissileX, MissileY} !== 22'd0 || kills_seen != k0) begin
            n_bad++; $display("FAIL midreset: got on=%b kill=%b x=%0d y=%0d want all 0", Missile_on, kill, MissileX, MissileY); end
        Reset = 1'b0;
        tick();
        n_cmp++; if ({Missile_on, MissileX, MissileY} !== {1'b1, 10'd500, 10'd284}) begin
            n_bad++; $display("FAIL post_reset_launch: got on=%b x=%0d y=%0d want on=1 x=500 y=284", Missile_on, MissileX, MissileY); end
    endtask

    task automatic test_launch_bounds();
        Reset = 1'b1; step(); Reset = 1'b0; step();
        ShipX = 10'd5; ShipY = 10'd22; keycode = 8'h2C;
        tick(); tick();
        n_cmp++; if (Missile_on !== 1'b1 || MissileY !== 10'd0) begin
            n_bad++; $display("FAIL exact_step: got on=%b y=%0d want on=1 y=0", Missile_on, MissileY); end
        tick();
        n_cmp++; if (Missile_on !== 1'b0 || MissileY !== 10'd0) begin
            n_bad++; $display("FAIL y0_retire: got on=%b y=%0d want on=0 y=0", Missile_on, MissileY); end
        Reset = 1'b1; step(); Reset = 1'b0; step();
        ShipY = 10'd15; tick();
        n_cmp++; if (Missile_on !== 1'b0) begin n_bad++; $display("FAIL low_ship_block: got on=%b want 0", Missile_on); end
        ShipY = 10'd16; tick();
        n_cmp++; if (Missile_on !== 1'b1 || MissileY !== 10'd0) begin
            n_bad++; $display("FAIL min_ship_launch: got on=%b y=%0d want on=1 y=0", Missile_on, MissileY); end
    endtask

    task automatic test_frame_edges();
        frame_clk = 1'b1; keycode = 8'h2C; ShipY = 10'd440;
        Reset = 1'b1; step(); Reset = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (Missile_on !== 1'b0) begin n_bad++; $display("FAIL high_at_release: got on=%b want 0", Missile_on); end
        frame_clk = 1'b0; step();
        frame_clk = 1'b1;
        for (int k = 0; k < 10; k++) step();
        n_cmp++; if (Missile_on !== 1'b1 || MissileY !== 10'd424) begin
            n_bad++; $display("FAIL held_high_one_tick: got on=%b y=%0d want on=1 y=424", Missile_on, MissileY); end
        frame_clk = 1'b0; step();
    endtask

    task automatic test_random();
        logic [21:0] got, want;
        int r;
        Reset = 1'b1; frame_clk = 1'b0; hit = 1'b0; step(); Reset = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            Reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            r = int'($urandom_range(0, 3));
            keycode = (r < 2) ? 8'h2C : (r == 2) ? 8'h00 : 8'($urandom);
            hit = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) begin
                ShipX = 10'($urandom_range(0, 639));
                ShipY = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 60)) : 10'($urandom_range(0, 479));
            end
            step();
            got  = {Missile_on, kill, MissileX, MissileY};
            want = {m_fly, m_kill, 10'(m_x), 10'(m_y)};
            n_cmp++; if (got !== want) begin
                n_bad++; $display("FAIL rand_%0d: got on=%b kill=%b x=%0d y=%0d want on=%b kill=%b x=%0d y=%0d",
                                  c, got[21], got[20], got[19:10], got[9:0], want[21], want[20], want[19:10], want[9:0]); end
        end
        Reset = 1'b0; hit = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; ShipX = '0; ShipY = '0; hit = 1'b0;
        test_reset();
        test_launch_climb();
        test_key_hold();
        test_hit();
        test_back_to_back();
        test_reset_midflight();
        test_launch_bounds();
        test_frame_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
